intr_predecode: RTL and testbench
=================================

INTR_PREDECODE -- requirements
Module: intr_predecode

Interface
REQ-001 Parameter BRK_OPCODE, default 8'h00: opcode injected into the predecode register when an interrupt is taken.
REQ-002 Parameter I_BIT, default 2: index of the interrupt-disable flag within statusReg.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, as fixed by the ports below.
REQ-004 phi1  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset; also the external reset request.
REQ-006 RDY  input  1  external ready; low SHALL freeze all state except rst handling.
REQ-007 nmiIn  input  1  external NMI request, active-high, edge-sensitive.
REQ-008 irqIn  input  1  external IRQ request, active-high, level-sensitive.
REQ-009 statusReg  input  8  processor status; bit I_BIT masks IRQ.
REQ-010 dataBus  input  8  opcode byte from memory.
REQ-011 T1now  input  1  FSM indicates the current cycle is an opcode-fetch cycle.
REQ-012 rstHandled, nmiHandled, irqHandled  input  1 each  one-cycle acknowledges from the control FSM.
REQ-013 rstReq  output  1  pending reset to the FSM rst input.
REQ-014 nmi  output  1  pending NMI to the FSM.
REQ-015 irq  output  1  pending unmasked IRQ to the FSM.
REQ-016 opcode  output  8  predecoded opcode register.
REQ-017 loadOpcode  output  1  one-cycle pulse marking a new opcode value.
REQ-018 intTaken  output  1  high while opcode holds an injected BRK_OPCODE.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 rstReq SHALL set on any cycle with rst high and clear only on a cycle with rstHandled high and rst low.
REQ-021 The block SHALL register nmiIn into nmiPrev each enabled cycle; a rising edge is nmiIn=1 with nmiPrev=0.
REQ-022 nmi SHALL set one cycle after a rising edge and hold until nmiHandled.
REQ-023 If a rising edge and nmiHandled coincide, nmi SHALL remain 1 (new edge wins).
REQ-024 A held-high nmiIn SHALL produce exactly one request.
REQ-025 irq SHALL equal the registered value of irqIn AND NOT statusReg[I_BIT], forced to 0 in the cycle after irqHandled.
REQ-026 Load condition: T1now=1 and RDY=1.
REQ-027 On load, opcode SHALL take BRK_OPCODE if rstReq, nmi or irq is 1 at that edge, else dataBus.
REQ-028 On load, intTaken SHALL take 1 for an injected BRK_OPCODE and 0 otherwise.
REQ-029 loadOpcode SHALL pulse high for exactly one cycle after each load edge.
REQ-030 Back-to-back load cycles SHALL yield back-to-back pulses.
REQ-031 Without a load, opcode and intTaken SHALL hold, and loadOpcode SHALL be 0.
REQ-032 A native BRK (dataBus=8'h00) with no pending request SHALL load 8'h00 with intTaken=0.
REQ-033 Priority for intTaken reporting SHALL be rstReq > nmi > irq; the FSM performs vector selection.
REQ-034 With RDY=0, nmi, irq, nmiPrev, opcode and intTaken SHALL hold, and loadOpcode SHALL be 0.
REQ-035 Edges on nmiIn during RDY=0 SHALL be detected on the first cycle after RDY rises, provided nmiIn is still high.
REQ-036 Acknowledge inputs SHALL be ignored while RDY=0.

Reset
REQ-037 On rst=1 at a clock edge, the block SHALL set rstReq=1, nmi=0, irq=0, nmiPrev=0, opcode=BRK_OPCODE, intTaken=1 and loadOpcode=0, regardless of RDY.
REQ-038 rst asserted mid-operation SHALL discard pending NMI and IRQ.
REQ-039 After rst falls, rstReq SHALL stay 1 until rstHandled.

Verification
REQ-040 Reset: rst high for 2 cycles, then low -> rstReq=1, opcode=8'h00, intTaken=1; rstHandled pulse -> rstReq=0 on the next cycle.
REQ-041 Fetch: dataBus=8'hA9, T1now=1, RDY=1, nothing pending -> next cycle opcode=8'hA9, loadOpcode=1 for one cycle, intTaken=0.
REQ-042 NMI edge: nmiIn held high for 10 cycles -> nmi=1 after 1 cycle; nmiHandled -> nmi=0 and stays 0; second rising edge coincident with nmiHandled -> nmi stays 1.
REQ-043 IRQ mask: irqIn=1 with statusReg=8'h04 -> irq=0; statusReg=8'h00 -> irq=1 one cycle later; T1now with dataBus=8'hEA -> opcode=8'h00, intTaken=1.
REQ-044 RDY stall: RDY=0 with T1now=1 and dataBus=8'h4C -> opcode unchanged, loadOpcode=0; RDY=1 -> opcode=8'h4C next cycle.
REQ-045 Reset mid-operation: nmi=1, irq=1, then rst for 1 cycle -> nmi=0, irq=0, rstReq=1, opcode=8'h00.

Source files
------------

// File: rtl/intr_predecode_if.sv
// Bundle between the interrupt predecoder and the surrounding core: request inputs,
// acknowledges from the control FSM, and the registered predecode outputs.
interface intr_predecode_if;
    logic       RDY;
    logic       nmiIn;
    logic       irqIn;
    logic [7:0] statusReg;
    logic [7:0] dataBus;
    logic       T1now;
    logic       rstHandled;
    logic       nmiHandled;
    logic       irqHandled;
    logic       rstReq;
    logic       nmi;
    logic       irq;
    logic [7:0] opcode;
    logic       loadOpcode;
    logic       intTaken;

    modport master (
        output RDY, nmiIn, irqIn, statusReg, dataBus, T1now,
               rstHandled, nmiHandled, irqHandled,
        input  rstReq, nmi, irq, opcode, loadOpcode, intTaken
    );

    modport slave (
        input  RDY, nmiIn, irqIn, statusReg, dataBus, T1now,
               rstHandled, nmiHandled, irqHandled,
        output rstReq, nmi, irq, opcode, loadOpcode, intTaken
    );
endinterface

// File: rtl/intr_predecode.sv
// Interrupt request conditioning and opcode predecode register: latches pending
// reset/NMI/IRQ and substitutes BRK_OPCODE on the fetch that takes an interrupt.
module intr_predecode #(
    parameter logic [7:0] BRK_OPCODE = 8'h00,
    parameter int         I_BIT      = 2
) (
    input  logic           phi1,
    input  logic           rst,
    intr_predecode_if.slave bus
);

    logic       rstReqQ;
    logic       nmiQ;
    logic       irqQ;
    logic       nmiPrev;
    logic [7:0] opcodeQ;
    logic       intTakenQ;
    logic       loadOpcodeQ;

    logic       nmiEdge;
    logic       loadNow;
    logic       inject;
    logic       irqMasked;

    assign nmiEdge   = bus.nmiIn & ~nmiPrev;
    assign loadNow   = bus.T1now & bus.RDY;
    // Decided from the registered requests, so a request arriving this cycle waits for the next fetch.
    assign inject    = rstReqQ | nmiQ | irqQ;
    assign irqMasked = bus.statusReg[I_BIT];

    // NOTE: every register here uses non-blocking assignment so all state samples
    // the pre-edge values together; blocking would leak new values into later lines.
    always_ff @(posedge phi1) begin
        if (rst) begin
            rstReqQ     <= 1'b1;
            nmiQ        <= 1'b0;
            irqQ        <= 1'b0;
            nmiPrev     <= 1'b0;
            opcodeQ     <= BRK_OPCODE;
            intTakenQ   <= 1'b1;
            loadOpcodeQ <= 1'b0;
        end else if (bus.RDY) begin
            if (bus.rstHandled)
                rstReqQ <= 1'b0;

            nmiPrev <= bus.nmiIn;
            if (nmiEdge)
                nmiQ <= 1'b1;
            else if (bus.nmiHandled)
                nmiQ <= 1'b0;

            irqQ <= bus.irqHandled ? 1'b0 : (bus.irqIn & ~irqMasked);

            loadOpcodeQ <= loadNow;
            if (loadNow) begin
                opcodeQ   <= inject ? BRK_OPCODE : bus.dataBus;
                intTakenQ <= inject;
            end
        end else begin
            // Stalled: everything holds and acknowledges are ignored.
            loadOpcodeQ <= 1'b0;
        end
    end

    assign bus.rstReq     = rstReqQ;
    assign bus.nmi        = nmiQ;
    assign bus.irq        = irqQ;
    assign bus.opcode     = opcodeQ;
    assign bus.intTaken   = intTakenQ;
    assign bus.loadOpcode = loadOpcodeQ;

endmodule

// File: tb/tb_intr_predecode.sv
// Self-checking bench for intr_predecode: directed scenarios against fixed expectations,
// then randomized traffic against a cycle-level behavioural model.
module tb_intr_predecode;

    localparam logic [7:0] BRK = 8'h00;

    logic phi1;
    logic rst;
    intr_predecode_if bus();

    intr_predecode #(.BRK_OPCODE(BRK), .I_BIT(2)) dut (
        .phi1 (phi1),
        .rst  (rst),
        .bus  (bus)
    );

    initial phi1 = 1'b0;
    always #5 phi1 = ~phi1;

    int cmpCount = 0;
    int errCount = 0;

    // Behavioural model state
    logic       mRst = 1'b0, mNmi = 1'b0, mIrq = 1'b0, mPrev = 1'b0;
    logic [7:0] mOp = 8'h00;
    logic       mInt = 1'b0, mLoad = 1'b0;

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic tick();
        logic       nRst, nNmi, nIrq, nPrev, nInt, nLoad, pending, edgeSeen;
        logic [7:0] nOp;
        nRst = mRst; nNmi = mNmi; nIrq = mIrq; nPrev = mPrev;
        nOp = mOp; nInt = mInt; nLoad = 1'b0;
        if (rst) begin
            nRst = 1'b1; nNmi = 1'b0; nIrq = 1'b0; nPrev = 1'b0;
            nOp = BRK; nInt = 1'b1;
        end else if (bus.RDY) begin
            pending  = mRst || mNmi || mIrq;
            edgeSeen = bus.nmiIn && !mPrev;
            if (bus.rstHandled) nRst = 1'b0;
            if (edgeSeen) nNmi = 1'b1;
            else if (bus.nmiHandled) nNmi = 1'b0;
            nPrev = bus.nmiIn;
            nIrq  = !bus.irqHandled && bus.irqIn && !bus.statusReg[2];
            if (bus.T1now) begin
                nOp   = pending ? BRK : bus.dataBus;
                nInt  = pending;
                nLoad = 1'b1;
            end
        end
        @(posedge phi1);
        mRst = nRst; mNmi = nNmi; mIrq = nIrq; mPrev = nPrev;
        mOp = nOp; mInt = nInt; mLoad = nLoad;
        #1;
    endtask

    task automatic idleInputs();
        bus.RDY = 1'b1; bus.nmiIn = 1'b0; bus.irqIn = 1'b0; bus.statusReg = 8'h00;
        bus.dataBus = 8'h00; bus.T1now = 1'b0;
        bus.rstHandled = 1'b0; bus.nmiHandled = 1'b0; bus.irqHandled = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        cmpCount++;
        if (bus.rstReq !== 1'b1 || bus.opcode !== 8'h00 || bus.intTaken !== 1'b1 ||
            bus.loadOpcode !== 1'b0 || bus.nmi !== 1'b0 || bus.irq !== 1'b0) begin
            errCount++;
            $display("FAIL reset_state: got rstReq=%b op=%h int=%b ld=%b nmi=%b irq=%b, want 1 00 1 0 0 0",
                     bus.rstReq, bus.opcode, bus.intTaken, bus.loadOpcode, bus.nmi, bus.irq);
        end
        tick();
        cmpCount++;
        if (bus.rstReq !== 1'b1) begin
            errCount++;
            $display("FAIL rstReq_hold: got %b want 1", bus.rstReq);
        end
        bus.rstHandled = 1'b1;
        tick();
        bus.rstHandled = 1'b0;
        cmpCount++;
        if (bus.rstReq !== 1'b0) begin
            errCount++;
            $display("FAIL rstReq_clear: got %b want 0", bus.rstReq);
        end
    endtask

    task automatic test_fetch();
        bus.dataBus = 8'hA9; bus.T1now = 1'b1;
        tick();
        bus.T1now = 1'b0;
        cmpCount++;
        if (bus.opcode !== 8'hA9 || bus.loadOpcode !== 1'b1 || bus.intTaken !== 1'b0) begin
            errCount++;
            $display("FAIL fetch_A9: got op=%h ld=%b int=%b want A9 1 0",
                     bus.opcode, bus.loadOpcode, bus.intTaken);
        end
        bus.dataBus = 8'h55;
        tick();
        cmpCount++;
        if (bus.opcode !== 8'hA9 || bus.loadOpcode !== 1'b0) begin
            errCount++;
            $display("FAIL fetch_hold: got op=%h ld=%b want A9 0", bus.opcode, bus.loadOpcode);
        end
    endtask

    task automatic test_back_to_back();
        bus.T1now = 1'b1; bus.dataBus = 8'h18;
        tick();
        cmpCount++;
        if (bus.opcode !== 8'h18 || bus.loadOpcode !== 1'b1) begin
            errCount++;
            $display("FAIL b2b_first: got op=%h ld=%b want 18 1", bus.opcode, bus.loadOpcode);
        end
        bus.dataBus = 8'h00;
        tick();
        bus.T1now = 1'b0;
        cmpCount++;
        if (bus.opcode !== 8'h00 || bus.loadOpcode !== 1'b1 || bus.intTaken !== 1'b0) begin
            errCount++;
            $display("FAIL b2b_native_brk: got op=%h ld=%b int=%b want 00 1 0",
                     bus.opcode, bus.loadOpcode, bus.intTaken);
        end
        tick();
    endtask

    task automatic test_nmi();
        bit stayedLow;
        bus.nmiIn = 1'b1;
        tick();
        cmpCount++;
        if (bus.nmi !== 1'b1) begin
            errCount++;
            $display("FAIL nmi_set: got %b want 1", bus.nmi);
        end
        bus.nmiHandled = 1'b1;
        tick();
        bus.nmiHandled = 1'b0;
        stayedLow = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (bus.nmi !== 1'b0) stayedLow = 1'b0;
            tick();
        end
        cmpCount++;
        if (!stayedLow || bus.nmi !== 1'b0) begin
            errCount++;
            $display("FAIL nmi_single_request: got nmi=%b stayedLow=%b want 0 1", bus.nmi, stayedLow);
        end
        bus.nmiIn = 1'b0; tick();
        bus.nmiIn = 1'b1; tick();
        bus.nmiIn = 1'b0; tick();
        bus.nmiIn = 1'b1; bus.nmiHandled = 1'b1;
        tick();
        bus.nmiHandled = 1'b0;
        cmpCount++;
        if (bus.nmi !== 1'b1) begin
            errCount++;
            $display("FAIL nmi_edge_beats_ack: got %b want 1", bus.nmi);
        end
        bus.nmiHandled = 1'b1; tick(); bus.nmiHandled = 1'b0;
        bus.nmiIn = 1'b0; tick();
        cmpCount++;
        if (bus.nmi !== 1'b0) begin
            errCount++;
            $display("FAIL nmi_final_clear: got %b want 0", bus.nmi);
        end
    endtask

    task automatic test_irq_mask();
        bus.irqIn = 1'b1; bus.statusReg = 8'h04;
        tick();
        cmpCount++;
        if (bus.irq !== 1'b0) begin
            errCount++;
            $display("FAIL irq_masked: got %b want 0", bus.irq);
        end
        bus.statusReg = 8'h00;
        tick();
        cmpCount++;
        if (bus.irq !== 1'b1) begin
            errCount++;
            $display("FAIL irq_unmasked: got %b want 1", bus.irq);
        end
        bus.T1now = 1'b1; bus.dataBus = 8'hEA;
        tick();
        bus.T1now = 1'b0;
        cmpCount++;
        if (bus.opcode !== 8'h00 || bus.intTaken !== 1'b1 || bus.loadOpcode !== 1'b1) begin
            errCount++;
            $display("FAIL irq_inject: got op=%h int=%b ld=%b want 00 1 1",
                     bus.opcode, bus.intTaken, bus.loadOpcode);
        end
        bus.irqHandled = 1'b1;
        tick();
        bus.irqHandled = 1'b0;
        cmpCount++;
        if (bus.irq !== 1'b0) begin
            errCount++;
            $display("FAIL irq_ack: got %b want 0", bus.irq);
        end
        bus.irqIn = 1'b0;
        tick();
    endtask

    task automatic test_rdy_stall();
        bus.T1now = 1'b1; bus.dataBus = 8'h20;
        tick();
        bus.RDY = 1'b0; bus.dataBus = 8'h4C;
        tick(); tick();
        cmpCount++;
        if (bus.opcode !== 8'h20 || bus.loadOpcode !== 1'b0) begin
            errCount++;
            $display("FAIL stall_hold: got op=%h ld=%b want 20 0", bus.opcode, bus.loadOpcode);
        end
        bus.RDY = 1'b1;
        tick();
        bus.T1now = 1'b0;
        cmpCount++;
        if (bus.opcode !== 8'h4C || bus.loadOpcode !== 1'b1) begin
            errCount++;
            $display("FAIL stall_release: got op=%h ld=%b want 4C 1", bus.opcode, bus.loadOpcode);
        end
        bus.RDY = 1'b0; bus.nmiIn = 1'b1;
        tick(); tick();
        cmpCount++;
        if (bus.nmi !== 1'b0) begin
            errCount++;
            $display("FAIL stall_nmi_frozen: got %b want 0", bus.nmi);
        end
        bus.RDY = 1'b1;
        tick();
        cmpCount++;
        if (bus.nmi !== 1'b1) begin
            errCount++;
            $display("FAIL stall_nmi_late_edge: got %b want 1", bus.nmi);
        end
        bus.RDY = 1'b0; bus.nmiHandled = 1'b1;
        tick();
        cmpCount++;
        if (bus.nmi !== 1'b1) begin
            errCount++;
            $display("FAIL stall_ack_ignored: got %b want 1", bus.nmi);
        end
        bus.RDY = 1'b1;
        tick();
        bus.nmiHandled = 1'b0; bus.nmiIn = 1'b0;
        cmpCount++;
        if (bus.nmi !== 1'b0) begin
            errCount++;
            $display("FAIL stall_ack_applied: got %b want 0", bus.nmi);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.nmiIn = 1'b1; bus.irqIn = 1'b1; bus.statusReg = 8'h00;
        tick();
        cmpCount++;
        if (bus.nmi !== 1'b1 || bus.irq !== 1'b1) begin
            errCount++;
            $display("FAIL mid_setup: got nmi=%b irq=%b want 1 1", bus.nmi, bus.irq);
        end
        bus.RDY = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; bus.RDY = 1'b1; bus.nmiIn = 1'b0; bus.irqIn = 1'b0;
        cmpCount++;
        if (bus.nmi !== 1'b0 || bus.irq !== 1'b0 || bus.rstReq !== 1'b1 ||
            bus.opcode !== 8'h00 || bus.intTaken !== 1'b1) begin
            errCount++;
            $display("FAIL mid_reset: got nmi=%b irq=%b rstReq=%b op=%h int=%b want 0 0 1 00 1",
                     bus.nmi, bus.irq, bus.rstReq, bus.opcode, bus.intTaken);
        end
        bus.rstHandled = 1'b1; tick(); bus.rstHandled = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst            = ($urandom_range(0, 39) == 0);
            bus.RDY        = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) bus.nmiIn = ~bus.nmiIn;
            bus.irqIn      = $urandom_range(0, 1);
            bus.statusReg  = 8'($urandom);
            bus.dataBus    = 8'($urandom);
            bus.T1now      = $urandom_range(0, 1);
            bus.rstHandled = ($urandom_range(0, 5) == 0);
            bus.nmiHandled = ($urandom_range(0, 3) == 0);
            bus.irqHandled = ($urandom_range(0, 3) == 0);
            tick();
            cmpCount++;
            if (bus.rstReq !== mRst || bus.nmi !== mNmi || bus.irq !== mIrq ||
                bus.opcode !== mOp || bus.intTaken !== mInt || bus.loadOpcode !== mLoad) begin
                errCount++;
                $display("FAIL random_cycle%0d: got rstReq=%b nmi=%b irq=%b op=%h int=%b ld=%b, want %b %b %b %h %b %b",
                         i, bus.rstReq, bus.nmi, bus.irq, bus.opcode, bus.intTaken, bus.loadOpcode,
                         mRst, mNmi, mIrq, mOp, mInt, mLoad);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idleInputs();
        test_reset();
        test_fetch();
        test_back_to_back();
        test_nmi();
        test_irq_mask();
        test_rdy_stall();
        test_reset_mid();
        idleInputs();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
